// File: rtl/sqrt_arb.sv
// sqrt_arb: four requesters share one sqrt16 through a round-robin arbiter; one root in flight.
// Latency: req_iv at edge E reaches sq_iv after E+2 when idle; ov follows a sampled sq_ov by one cycle.
// Backpressure: one-entry hold per channel (req_busy); a sample hitting a full channel is dropped (drop pulse).
// Build option: define SQRT_ARB_TIMEOUT_EN to add a WAIT watchdog of TMO cycles that aborts with err.
module sqrt_arb #(
  parameter int TMO = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] req_din,
  input  logic [3:0]   req_iv,
  output logic [3:0]   req_busy,
  output logic [3:0]   drop,
  output logic [31:0]  sq_din,
  output logic         sq_iv,
  input  logic [15:0]  sq_dout,
  input  logic         sq_ov,
  output logic [15:0]  dout,
  output logic [1:0]   och,
  output logic         ov,
  output logic         err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       pend_q, pend_d;
  logic [3:0][31:0] hold_q, hold_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       last_q, last_d;
  logic             sq_iv_q, sq_iv_d;
  logic [31:0]      sq_din_q, sq_din_d;
  logic [15:0]      dout_q, dout_d;
  logic [1:0]       och_q, och_d;
  logic             ov_q, ov_d;
  logic [3:0]       drop_q, drop_d;

  logic [3:0]       clr;
  logic [1:0]       pick;
  logic [1:0]       idx;
  logic             found;

`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TMO + 1);
  logic [WDW-1:0]   wd_q, wd_d;
  logic             err_q, err_d;
`endif

  // Round-robin pick: first pending channel scanning last+1, last+2, last+3, last.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && pend_q[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Arbiter FSM plus per-channel holding registers and drop detection.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    hold_d   = hold_q;
    grant_d  = grant_q;
    last_d   = last_q;
    sq_iv_d  = 1'b0;
    sq_din_d = sq_din_q;
    dout_d   = dout_q;
    och_d    = och_q;
    ov_d     = 1'b0;
    drop_d   = '0;
    clr      = '0;
`ifdef SQRT_ARB_TIMEOUT_EN
    wd_d     = wd_q;
    err_d    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          grant_d = pick;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        sq_iv_d      = 1'b1;
        sq_din_d     = hold_q[grant_q];
        clr[grant_q] = 1'b1;
        last_d       = grant_q;
        state_d      = S_WAIT;
`ifdef SQRT_ARB_TIMEOUT_EN
        wd_d         = '0;
`endif
      end
      S_WAIT: begin
        if (sq_ov) begin
          dout_d  = sq_dout;
          och_d   = grant_q;
          ov_d    = 1'b1;
          state_d = S_IDLE;
        end
`ifdef SQRT_ARB_TIMEOUT_EN
        // Root never came back: abandon it so other channels are not starved.
        else if (wd_q == WDW'(TMO - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // A channel being issued this cycle frees its slot, so a same-cycle sample is accepted.
    for (int k = 0; k < 4; k++) begin
      if (req_iv[k]) begin
        if (!pend_q[k] || clr[k]) begin
          hold_d[k] = req_din[32*k +: 32];
          pend_d[k] = 1'b1;
        end else begin
          drop_d[k] = 1'b1;
        end
      end else if (clr[k]) begin
        pend_d[k] = 1'b0;
      end
    end
  end

  // State registers with synchronous reset; last=3 gives channel 0 first turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      hold_q   <= '0;
      grant_q  <= '0;
      last_q   <= 2'd3;
      sq_iv_q  <= 1'b0;
      sq_din_q <= '0;
      dout_q   <= '0;
      och_q    <= '0;
      ov_q     <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      hold_q   <= hold_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      sq_iv_q  <= sq_iv_d;
      sq_din_q <= sq_din_d;
      dout_q   <= dout_d;
      och_q    <= och_d;
      ov_q     <= ov_d;
      drop_q   <= drop_d;
    end
  end

`ifdef SQRT_ARB_TIMEOUT_EN
  // Watchdog counter and abort pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign req_busy = pend_q;
  assign drop     = drop_q;
  assign sq_iv    = sq_iv_q;
  assign sq_din   = sq_din_q;
  assign dout     = dout_q;
  assign och      = och_q;
  assign ov       = ov_q;

endmodule

// File: tb/tb_sqrt_arb.sv
// tb_sqrt_arb: scoreboard bench for sqrt_arb with a behavioural sqrt16 responder.
// Expected issues/results are queued at stimulus time; a negedge monitor pops and compares.
// Covers reset, latency, round-robin order, drops, fairness, stalls, watchdog (when enabled).
module tb_sqrt_arb;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] req_din = '0;
  logic [3:0]   req_iv = '0;
  logic [3:0]   req_busy;
  logic [3:0]   drop;
  logic [31:0]  sq_din;
  logic         sq_iv;
  logic [15:0]  sq_dout = '0;
  logic         sq_ov = 1'b0;
  logic [15:0]  dout;
  logic [1:0]   och;
  logic         ov;
  logic         err;

  int n_checks = 0;
  int n_fail = 0;
  int ov_cnt = 0;
  int err_cnt = 0;
  int drop_cnt [4] = '{0, 0, 0, 0};
  int exp_drop [4] = '{0, 0, 0, 0};

  logic [31:0] iss_q [$];
  logic [17:0] res_q [$];
  logic [15:0] exp_dout = '0;
  logic [1:0]  exp_och = '0;
  logic [31:0] exp_sq_din = '0;
  bit          outstanding = 1'b0;
  int          last_m = 3;

  bit stub = 1'b0;
  int lat = 2;
  int inj_req = 0;
  int inj_done = 0;

  always #5 clk = ~clk;

  sqrt_arb #(.TMO(24)) dut (
    .clk(clk), .rst(rst), .req_din(req_din), .req_iv(req_iv),
    .req_busy(req_busy), .drop(drop), .sq_din(sq_din), .sq_iv(sq_iv),
    .sq_dout(sq_dout), .sq_ov(sq_ov), .dout(dout), .och(och),
    .ov(ov), .err(err)
  );

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    logic [63:0] r;
    logic [63:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r + (64'd1 << b);
      if (t * t <= {32'd0, x}) r = t;
    end
    return r[15:0];
  endfunction

  function automatic int rr_next(input logic [3:0] mask, input int last);
    int k;
    for (int i = 1; i <= 4; i++) begin
      k = (last + i) % 4;
      if (mask[k]) return k;
    end
    return last;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural sqrt16: answers lat cycles after sq_iv, or never while stubbed.
  initial begin : sqrt16_model
    int cnt;
    logic [15:0] root;
    cnt = 0;
    root = '0;
    forever begin
      @(posedge clk);
      #1;
      sq_ov = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (inj_req != inj_done) begin
        sq_ov = 1'b1;
        sq_dout = 16'hBEEF;
        inj_done++;
      end else if (sq_iv && !stub) begin
        root = isqrt(sq_din);
        cnt = lat;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          sq_ov = 1'b1;
          sq_dout = root;
        end
      end
    end
  end

  // Monitor: pops expectations when the DUT issues or returns, checks holds otherwise.
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst) begin
      outstanding = 1'b0;
      exp_dout = '0;
      exp_och = '0;
      exp_sq_din = '0;
    end else begin
      if (sq_ov) outstanding = 1'b0;
      if (err) begin
        err_cnt++;
        outstanding = 1'b0;
      end
      for (int k = 0; k < 4; k++) drop_cnt[k] += int'(drop[k]);
      if (sq_iv) begin
        check("single_root_in_flight", outstanding, 0);
        outstanding = 1'b1;
        if (iss_q.size() == 0) begin
          check("unexpected_sq_iv", sq_iv, 0);
        end else begin
          exp_sq_din = iss_q.pop_front();
          check("sq_din", sq_din, exp_sq_din);
        end
      end else begin
        check("sq_din_hold", sq_din, exp_sq_din);
        if (sq_din !== exp_sq_din) exp_sq_din = sq_din;
      end
      if (ov) begin
        ov_cnt++;
        if (res_q.size() == 0) begin
          check("unexpected_ov", ov, 0);
          exp_dout = dout;
          exp_och = och;
        end else begin
          e = res_q.pop_front();
          check("och", och, e[17:16]);
          check("dout", dout, e[15:0]);
          exp_och = e[17:16];
          exp_dout = e[15:0];
        end
      end else begin
        check("dout_och_hold", {och, dout}, {exp_och, exp_dout});
        if ({och, dout} !== {exp_och, exp_dout}) begin
          exp_dout = dout;
          exp_och = och;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req_iv = '0;
    tick(2);
    iss_q.delete();
    res_q.delete();
    last_m = 3;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_busy"}, req_busy, 0);
    check({tag, "_drop"}, drop, 0);
    check({tag, "_sq_iv"}, sq_iv, 0);
    check({tag, "_sq_din"}, sq_din, 0);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_och"}, och, 0);
    check({tag, "_ov"}, ov, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Simultaneous requests on mask; results expected in round-robin order from last_m.
  task automatic burst(input logic [3:0] mask, input logic [31:0] v [4]);
    int k;
    int l;
    l = last_m;
    for (int i = 1; i <= 4; i++) begin
      k = (l + i) % 4;
      if (mask[k]) begin
        iss_q.push_back(v[k]);
        res_q.push_back({2'(k), isqrt(v[k])});
        last_m = k;
      end
    end
    for (int c = 0; c < 4; c++) req_din[32*c +: 32] = v[c];
    req_iv = mask;
    tick(1);
    req_iv = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((iss_q.size() != 0 || res_q.size() != 0) && n < 500) begin
      tick(1);
      n++;
    end
    check("drain_done", (n < 500), 1);
    tick(2);
  endtask

  task automatic wait_sq_iv();
    int n;
    n = 0;
    while (!sq_iv && n < 200) begin
      tick(1);
      n++;
    end
    check("sq_iv_arrives", sq_iv, 1);
  endtask

  initial begin : global_guard
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] v [4];
    logic [31:0] held [2];
    logic [31:0] a, b, c;
    logic [3:0]  m;
    int n, g, f, s, prev_ov, prev_err;

    do_reset();
    check_reset_outputs("reset");

    // Single request: fixed vector and issue latency.
    lat = 3;
    req_din[31:0] = 32'd144;
    req_iv = 4'b0001;
    iss_q.push_back(32'd144);
    res_q.push_back({2'd0, 16'd12});
    last_m = 0;
    tick(1);
    req_iv = '0;
    n = 1;
    while (!sq_iv && n < 20) begin
      tick(1);
      n++;
    end
    check("issue_latency", n, 3);
    drain();

    // All four channels in one cycle from reset: order 0,1,2,3.
    do_reset();
    v = '{32'd140, 32'd144, 32'd148, 32'd36864};
    burst(4'hF, v);
    drain();

    // Extreme radicands.
    v = '{32'd0, 32'd0, 32'd65025, 32'd4294836225};
    burst(4'b0100, v);
    drain();
    burst(4'b1000, v);
    drain();
    v = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'd3};
    burst(4'hF, v);
    drain();

    // Random masks, values and sqrt latencies; occasional stray sq_ov while idle.
    for (int it = 0; it < 40; it++) begin
      m = 4'($urandom_range(1, 15));
      for (int k = 0; k < 4; k++) begin
        v[k] = $urandom;
        if ($urandom_range(0, 2) == 0) v[k] = $urandom_range(0, 70000);
      end
      lat = $urandom_range(1, 6);
      burst(m, v);
      drain();
      if (it % 8 == 3) begin
        prev_ov = ov_cnt;
        inj_req++;
        tick(3);
        check("ignored_sq_ov_idle", ov_cnt, prev_ov);
      end
    end

    // Channel 1 hammered while channel 0's root is in flight.
    lat = 12;
    v[0] = $urandom;
    burst(4'b0001, v);
    wait_sq_iv();
    a = $urandom; b = $urandom; c = $urandom;
    iss_q.push_back(a);
    res_q.push_back({2'd1, isqrt(a)});
    req_din[63:32] = a; req_iv = 4'b0010; tick(1);
    req_din[63:32] = b; tick(1);
    req_din[63:32] = c; tick(1);
    req_iv = '0;
    check("busy_while_held", req_busy[1], 1);
    exp_drop[1] += 2;
    last_m = 1;
    drain();

    // Back-to-back on idle channel 2: capture, drop, capture on the issue cycle.
    lat = $urandom_range(1, 5);
    a = $urandom; b = $urandom; c = $urandom;
    iss_q.push_back(a); res_q.push_back({2'd2, isqrt(a)});
    iss_q.push_back(c); res_q.push_back({2'd2, isqrt(c)});
    req_din[95:64] = a; req_iv = 4'b0100; tick(1);
    req_din[95:64] = b; tick(1);
    req_din[95:64] = c; tick(1);
    req_iv = '0;
    exp_drop[2] += 1;
    last_m = 2;
    drain();
    for (int k = 0; k < 4; k++) check("drop_count", drop_cnt[k], exp_drop[k]);

    // Fairness: channels 0 and 1 kept pending, grants must alternate.
    lat = $urandom_range(1, 4);
    held[0] = $urandom;
    held[1] = $urandom;
    g = rr_next(4'b0011, last_m);
    iss_q.push_back(held[g]);
    res_q.push_back({2'(g), isqrt(held[g])});
    req_din[31:0] = held[0];
    req_din[63:32] = held[1];
    req_iv = 4'b0011;
    tick(1);
    req_iv = '0;
    for (int i = 0; i < 8; i++) begin
      wait_sq_iv();
      held[g] = $urandom;
      req_din[32*g +: 32] = held[g];
      req_iv = 4'(1 << g);
      tick(1);
      req_iv = '0;
      g = g ^ 1;
      iss_q.push_back(held[g]);
      res_q.push_back({2'(g), isqrt(held[g])});
    end
    iss_q.push_back(held[g ^ 1]);
    res_q.push_back({2'(g ^ 1), isqrt(held[g ^ 1])});
    last_m = g ^ 1;
    drain();

`ifdef SQRT_ARB_TIMEOUT_EN
    // Watchdog: first root abandoned after 24 WAIT cycles, second channel then served.
    stub = 1'b1;
    lat = 2;
    v[1] = $urandom;
    v[3] = $urandom;
    f = rr_next(4'b1010, last_m);
    s = (f == 1) ? 3 : 1;
    iss_q.push_back(v[f]);
    iss_q.push_back(v[s]);
    res_q.push_back({2'(s), isqrt(v[s])});
    req_din[63:32] = v[1];
    req_din[127:96] = v[3];
    req_iv = 4'b1010;
    tick(1);
    req_iv = '0;
    wait_sq_iv();
    prev_ov = ov_cnt;
    n = 0;
    while (!err && n < 60) begin
      tick(1);
      n++;
    end
    check("err_delay", n, 24);
    check("no_ov_on_abort", ov_cnt, prev_ov);
    stub = 1'b0;
    last_m = s;
    drain();
    check("err_pulses", err_cnt, 1);
`endif

    // Root never returns; reset while stuck in WAIT.
    stub = 1'b1;
    v[0] = $urandom;
    iss_q.push_back(v[0]);
    req_din[31:0] = v[0];
    req_iv = 4'b0001;
    tick(1);
    req_iv = '0;
    wait_sq_iv();
    req_din[95:64] = $urandom;
    req_iv = 4'b0100;
    tick(1);
    req_iv = '0;
    prev_ov = ov_cnt;
    prev_err = err_cnt;
`ifdef SQRT_ARB_TIMEOUT_EN
    tick(10);
`else
    tick(40);
`endif
    check("no_ov_while_stalled", ov_cnt, prev_ov);
    check("no_err_while_stalled", err_cnt, prev_err);
    check("busy_during_stall", req_busy, 4'b0100);
    rst = 1'b1;
    tick(1);
    check_reset_outputs("mid_wait_reset");
    iss_q.delete();
    res_q.delete();
    last_m = 3;
    rst = 1'b0;
    tick(1);
    check_reset_outputs("after_reset");
    stub = 1'b0;
    prev_ov = ov_cnt;
    inj_req++;
    tick(4);
    check("stale_sq_ov_ignored", ov_cnt, prev_ov);
    lat = 2;
    v[1] = 32'd400;
    burst(4'b0010, v);
    drain();
    for (int k = 0; k < 4; k++) check("final_drop_count", drop_cnt[k], exp_drop[k]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
